rc4_decrypt_core: RTL and testbench

RC4_DECRYPT_CORE -- requirements
Module: rc4_decrypt_core

---
 rtl/rc4_decrypt_core.sv | 194 +++++++++++++++++++
 tb/tb_rc4_decrypt_core.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_decrypt_core.sv
// RC4 decryption core: S-box init, key schedule and keystream XOR over an external
// S-array RAM, ciphertext ROM and plaintext RAM, with optional printable-text early abort.
module rc4_decrypt_core #(
  parameter int KEY_BYTES   = 3,
  parameter int MSG_LEN     = 32,
  parameter int CHECK_ASCII = 1,
  localparam int CT_AW      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_din,
  output logic                   s_wren,
  input  logic [7:0]             s_dout,
  output logic [CT_AW-1:0]       ct_addr,
  input  logic [7:0]             ct_dout,
  output logic [CT_AW-1:0]       pt_addr,
  output logic [7:0]             pt_din,
  output logic                   pt_wren,
  output logic                   done,
  output logic                   key_ok
);

  // state        | meaning
  // IDLE / DONE  | waiting for en (DONE also holds done and key_ok)
  // INIT         | S[i] = i, one entry per cycle
  // K_*          | key schedule: read S[i], read S[j], swap
  // P_*          | keystream: read S[i], read S[j], swap, read S[si+sj] and ct[k], write pt[k]
  typedef enum logic [4:0] {
    IDLE, INIT, K_RI, K_WI, K_RJ, K_WJ, K_SWI, K_SWJ,
    P_RI, P_WI, P_RJ, P_WJ, P_SWI, P_SWJ, P_RF, P_WF, P_OUT, DONE
  } state_t;

  localparam logic [CT_AW-1:0] K_LAST = CT_AW'(MSG_LEN - 1);

  state_t                 state, state_n;
  logic [7:0]             i, j, si, sj, f, ct;
  logic [CT_AW-1:0]       k;
  logic [8*KEY_BYTES-1:0] key_r;
  logic [7:0]             i_nxt, j_ksa, j_prga, f_addr, pt_byte;
  logic                   ascii_ok, abort;

  // key_r rotates one byte per KSA step so its top byte is always key[i mod KEY_BYTES]
  assign i_nxt    = i + 8'd1;
  assign j_ksa    = j + si + key_r[8*KEY_BYTES-1 -: 8];
  assign j_prga   = j + si;
  assign f_addr   = si + sj;
  assign pt_byte  = f ^ ct;
  assign ascii_ok = (pt_byte == 8'h20) || ((pt_byte >= 8'h61) && (pt_byte <= 8'h7A));
  assign abort    = (CHECK_ASCII != 0) && !ascii_ok;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i      <= 8'h00;
      j      <= 8'h00;
      k      <= '0;
      si     <= 8'h00;
      sj     <= 8'h00;
      f      <= 8'h00;
      ct     <= 8'h00;
      key_r  <= '0;
      key_ok <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (en) begin
            key_r  <= key;
            key_ok <= 1'b0;
            i      <= 8'h00;
            j      <= 8'h00;
            k      <= '0;
          end
        end
        INIT:       i <= i_nxt;
        K_WI, P_WI: si <= s_dout;
        K_RJ:       j <= j_ksa;
        K_WJ, P_WJ: sj <= s_dout;
        K_SWJ: begin
          i     <= i_nxt;
          key_r <= (key_r << 8) | (key_r >> (8*KEY_BYTES - 8));
          if (i == 8'hFF) j <= 8'h00;
        end
        P_RI:       i <= i_nxt;
        P_RJ:       j <= j_prga;
        P_WF: begin
          f  <= s_dout;
          ct <= ct_dout;
        end
        P_OUT: begin
          if (abort)            key_ok <= 1'b0;
          else if (k == K_LAST) key_ok <= 1'b1;
          else                  k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    rdy     = 1'b0;
    done    = 1'b0;
    s_addr  = 8'h00;
    s_din   = 8'h00;
    s_wren  = 1'b0;
    ct_addr = '0;
    pt_addr = '0;
    pt_din  = 8'h00;
    pt_wren = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) state_n = INIT;
      end
      INIT: begin
        s_addr = i;
        s_din  = i;
        s_wren = 1'b1;
        if (i == 8'hFF) state_n = K_RI;
      end
      K_RI: begin
        s_addr  = i;
        state_n = K_WI;
      end
      K_WI: state_n = K_RJ;
      K_RJ: begin
        s_addr  = j_ksa;
        state_n = K_WJ;
      end
      K_WJ: state_n = K_SWI;
      K_SWI: begin
        s_addr  = i;
        s_din   = sj;
        s_wren  = 1'b1;
        state_n = K_SWJ;
      end
      K_SWJ: begin
        s_addr  = j;
        s_din   = si;
        s_wren  = 1'b1;
        state_n = (i == 8'hFF) ? P_RI : K_RI;
      end
      P_RI: begin
        s_addr  = i_nxt;
        state_n = P_WI;
      end
      P_WI: state_n = P_RJ;
      P_RJ: begin
        s_addr  = j_prga;
        state_n = P_WJ;
      end
      P_WJ: state_n = P_SWI;
      P_SWI: begin
        s_addr  = i;
        s_din   = sj;
        s_wren  = 1'b1;
        state_n = P_SWJ;
      end
      P_SWJ: begin
        s_addr  = j;
        s_din   = si;
        s_wren  = 1'b1;
        state_n = P_RF;
      end
      P_RF: begin
        s_addr  = f_addr;
        ct_addr = k;
        state_n = P_WF;
      end
      P_WF: state_n = P_OUT;
      P_OUT: begin
        pt_addr = k;
        pt_din  = pt_byte;
        pt_wren = 1'b1;
        state_n = (abort || (k == K_LAST)) ? DONE : P_RI;
      end
      DONE: begin
        rdy  = 1'b1;
        done = 1'b1;
        if (en) state_n = INIT;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Bench for rc4_decrypt_core: three instances (plain, ASCII-checked, 5-byte key) with
// behavioural RAM/ROM models and a per-instance scoreboard of expected plaintext writes.
module tb_rc4_decrypt_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en_a, en_b, en_c, pt_clear;
  logic [23:0] key3;
  logic [39:0] key5;

  logic       rdy_a, s_wren_a, pt_wren_a, done_a, key_ok_a;
  logic [7:0] s_addr_a, s_din_a, s_dout_a, ct_dout_a, pt_din_a;
  logic [3:0] ct_addr_a, pt_addr_a;
  logic       rdy_b, s_wren_b, pt_wren_b, done_b, key_ok_b;
  logic [7:0] s_addr_b, s_din_b, s_dout_b, ct_dout_b, pt_din_b;
  logic [3:0] ct_addr_b, pt_addr_b;
  logic       rdy_c, s_wren_c, pt_wren_c, done_c, key_ok_c;
  logic [7:0] s_addr_c, s_din_c, s_dout_c, ct_dout_c, pt_din_c;
  logic [0:0] ct_addr_c, pt_addr_c;

  rc4_decrypt_core #(.KEY_BYTES(3), .MSG_LEN(9), .CHECK_ASCII(0)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .rdy(rdy_a), .key(key3),
    .s_addr(s_addr_a), .s_din(s_din_a), .s_wren(s_wren_a), .s_dout(s_dout_a),
    .ct_addr(ct_addr_a), .ct_dout(ct_dout_a),
    .pt_addr(pt_addr_a), .pt_din(pt_din_a), .pt_wren(pt_wren_a),
    .done(done_a), .key_ok(key_ok_a));

  rc4_decrypt_core #(.KEY_BYTES(3), .MSG_LEN(9), .CHECK_ASCII(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .rdy(rdy_b), .key(key3),
    .s_addr(s_addr_b), .s_din(s_din_b), .s_wren(s_wren_b), .s_dout(s_dout_b),
    .ct_addr(ct_addr_b), .ct_dout(ct_dout_b),
    .pt_addr(pt_addr_b), .pt_din(pt_din_b), .pt_wren(pt_wren_b),
    .done(done_b), .key_ok(key_ok_b));

  rc4_decrypt_core #(.KEY_BYTES(5), .MSG_LEN(1), .CHECK_ASCII(0)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .rdy(rdy_c), .key(key5),
    .s_addr(s_addr_c), .s_din(s_din_c), .s_wren(s_wren_c), .s_dout(s_dout_c),
    .ct_addr(ct_addr_c), .ct_dout(ct_dout_c),
    .pt_addr(pt_addr_c), .pt_din(pt_din_c), .pt_wren(pt_wren_c),
    .done(done_c), .key_ok(key_ok_c));

  // memory models
  logic [7:0] s_mem_a[256], s_mem_b[256], s_mem_c[256];
  logic [7:0] ct_mem_ab[16], ct_mem_c[2];
  logic [7:0] pt_mem_a[16], pt_mem_b[16], pt_mem_c[2];
  logic [7:0] pt_exp[9];

  always @(posedge clk) begin
    if (s_wren_a) s_mem_a[s_addr_a] <= s_din_a;
    if (s_wren_b) s_mem_b[s_addr_b] <= s_din_b;
    if (s_wren_c) s_mem_c[s_addr_c] <= s_din_c;
    s_dout_a  <= s_mem_a[s_addr_a];
    s_dout_b  <= s_mem_b[s_addr_b];
    s_dout_c  <= s_mem_c[s_addr_c];
    ct_dout_a <= ct_mem_ab[ct_addr_a];
    ct_dout_b <= ct_mem_ab[ct_addr_b];
    ct_dout_c <= ct_mem_c[ct_addr_c];
  end

  always @(posedge clk) begin
    if (pt_clear) begin
      for (int n = 0; n < 16; n++) begin
        pt_mem_a[n] <= 8'hEE;
        pt_mem_b[n] <= 8'hEE;
      end
      pt_mem_c[0] <= 8'hEE;
      pt_mem_c[1] <= 8'hEE;
    end else begin
      if (pt_wren_a) pt_mem_a[pt_addr_a] <= pt_din_a;
      if (pt_wren_b) pt_mem_b[pt_addr_b] <= pt_din_b;
      if (pt_wren_c) pt_mem_c[pt_addr_c] <= pt_din_c;
    end
  end

  initial begin
    logic [71:0] ctv, ptv;
    ctv = 72'hBBF316E8D940AF0AD3;
    ptv = 72'h506C61696E74657874;
    for (int n = 0; n < 16; n++) ct_mem_ab[n] = 8'h00;
    for (int n = 0; n < 9; n++) begin
      ct_mem_ab[n] = ctv[71-8*n -: 8];
      pt_exp[n]    = ptv[71-8*n -: 8];
    end
    ct_mem_c[0] = 8'h00;
    ct_mem_c[1] = 8'h00;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int t0;

  // scoreboard: {addr, data} of each expected plaintext write, in order
  logic [15:0] q_a[$], q_b[$], q_c[$];
  logic [15:0] exp_a, exp_b, exp_c, act_a, act_b, act_c;

  always @(negedge clk) begin
    if (pt_wren_a) begin
      act_a = {4'h0, pt_addr_a, pt_din_a};
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL pt_write_a unexpected got=%h", act_a);
      end else begin
        exp_a = q_a.pop_front();
        if (act_a !== exp_a) begin
          errors++;
          $display("FAIL pt_write_a got=%h exp=%h", act_a, exp_a);
        end
      end
    end
    if (pt_wren_b) begin
      act_b = {4'h0, pt_addr_b, pt_din_b};
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL pt_write_b unexpected got=%h", act_b);
      end else begin
        exp_b = q_b.pop_front();
        if (act_b !== exp_b) begin
          errors++;
          $display("FAIL pt_write_b got=%h exp=%h", act_b, exp_b);
        end
      end
    end
    if (pt_wren_c) begin
      act_c = {7'h0, pt_addr_c, pt_din_c};
      checks++;
      if (q_c.size() == 0) begin
        errors++;
        $display("FAIL pt_write_c unexpected got=%h", act_c);
      end else begin
        exp_c = q_c.pop_front();
        if (act_c !== exp_c) begin
          errors++;
          $display("FAIL pt_write_c got=%h exp=%h", act_c, exp_c);
        end
      end
    end
  end

  // reference RC4 keystream
  logic [7:0] m_s[256];
  logic [7:0] m_ks[256];

  task automatic rc4_model(input logic [255:0] mk, input int kb, input int n);
    int ii, jj;
    logic [7:0] t;
    for (int x = 0; x < 256; x++) m_s[x] = 8'(x);
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + int'(m_s[x]) + int'(mk[8*(kb-1-(x % kb)) +: 8])) & 255;
      t = m_s[x]; m_s[x] = m_s[jj]; m_s[jj] = t;
    end
    ii = 0;
    jj = 0;
    for (int b = 0; b < n; b++) begin
      ii = (ii + 1) & 255;
      jj = (jj + int'(m_s[ii])) & 255;
      t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
      m_ks[b] = m_s[(int'(m_s[ii]) + int'(m_s[jj])) & 255];
    end
  endtask

  task automatic clear_pt();
    @(negedge clk);
    pt_clear = 1'b1;
    @(negedge clk);
    pt_clear = 1'b0;
  endtask

  task automatic push_plaintext_a();
    for (int n = 0; n < 9; n++) q_a.push_back({8'(n), pt_exp[n]});
  endtask

  // start selected instances together; disturb pulses en_a once in INIT and once in PRGA
  task automatic run(input bit ga, input bit gb, input bit gc, input bit disturb,
                     output int la, output int lb, output int lc);
    @(negedge clk);
    en_a = ga; en_b = gb; en_c = gc;
    @(posedge clk);
    #1;
    t0 = cyc;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    if (ga) begin
      checks++;
      if (rdy_a !== 1'b0) begin errors++; $display("FAIL rdy_fall_a got=%b exp=0", rdy_a); end
    end
    la = -1; lb = -1; lc = -1;
    for (int n = 1; n <= 2500; n++) begin
      @(negedge clk);
      if (ga && la < 0 && done_a) la = cyc - t0;
      if (gb && lb < 0 && done_b) lb = cyc - t0;
      if (gc && lc < 0 && done_c) lc = cyc - t0;
      en_a = disturb && (n == 10 || n == 1795);
      if ((!ga || la >= 0) && (!gb || lb >= 0) && (!gc || lc >= 0)) break;
    end
    en_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rdy_a, done_a, key_ok_a, s_wren_a, pt_wren_a} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags_a got=%b exp=10000", {rdy_a, done_a, key_ok_a, s_wren_a, pt_wren_a});
    end
    checks++;
    if ({rdy_b, done_b, key_ok_b, s_wren_b, pt_wren_b} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags_b got=%b exp=10000", {rdy_b, done_b, key_ok_b, s_wren_b, pt_wren_b});
    end
    checks++;
    if ({rdy_c, done_c, key_ok_c, s_wren_c, pt_wren_c} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags_c got=%b exp=10000", {rdy_c, done_c, key_ok_c, s_wren_c, pt_wren_c});
    end
    checks++;
    if ({s_addr_a, ct_addr_a, pt_addr_a} !== 16'h0) begin
      errors++; $display("FAIL reset_addr_a got=%h exp=0", {s_addr_a, ct_addr_a, pt_addr_a});
    end
    checks++;
    if ({s_addr_c, ct_addr_c, pt_addr_c} !== 10'h0) begin
      errors++; $display("FAIL reset_addr_c got=%h exp=0", {s_addr_c, ct_addr_c, pt_addr_c});
    end
    rst = 1'b0;
    en_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({rdy_a, s_wren_a} !== 2'b10) begin
      errors++; $display("FAIL en_during_reset got=%b exp=10", {rdy_a, s_wren_a});
    end
  endtask

  task automatic test_vectors();
    int la, lb, lc;
    key3 = 24'h4B6579;
    key5 = 40'h0102030405;
    clear_pt();
    push_plaintext_a();
    q_b.push_back({8'h00, 8'h50});
    q_c.push_back({8'h00, 8'hB2});
    run(1'b1, 1'b1, 1'b1, 1'b0, la, lb, lc);
    checks++;
    if (la !== 1873) begin errors++; $display("FAIL latency_a got=%0d exp=1873", la); end
    checks++;
    if (lb !== 1801) begin errors++; $display("FAIL latency_abort_b got=%0d exp=1801", lb); end
    checks++;
    if (lc !== 1801) begin errors++; $display("FAIL latency_c got=%0d exp=1801", lc); end
    checks++;
    if ({done_a, key_ok_a} !== 2'b11) begin errors++; $display("FAIL key_ok_a got=%b exp=11", {done_a, key_ok_a}); end
    checks++;
    if ({done_b, key_ok_b} !== 2'b10) begin errors++; $display("FAIL key_ok_b got=%b exp=10", {done_b, key_ok_b}); end
    checks++;
    if ({done_c, key_ok_c} !== 2'b11) begin errors++; $display("FAIL key_ok_c got=%b exp=11", {done_c, key_ok_c}); end
    for (int n = 1; n < 9; n++) begin
      checks++;
      if (pt_mem_b[n] !== 8'hEE) begin
        errors++; $display("FAIL pt_untouched_b[%0d] got=%h exp=ee", n, pt_mem_b[n]);
      end
    end
    checks++;
    if (pt_mem_c[0] !== 8'hB2) begin errors++; $display("FAIL pt_mem_c got=%h exp=b2", pt_mem_c[0]); end
    checks++;
    if (q_a.size() + q_b.size() + q_c.size() != 0) begin
      errors++; $display("FAIL missing_writes got=%0d exp=0", q_a.size() + q_b.size() + q_c.size());
    end
  endtask

  task automatic test_busy_en();
    int la, lb, lc;
    clear_pt();
    push_plaintext_a();
    run(1'b1, 1'b0, 1'b0, 1'b1, la, lb, lc);
    checks++;
    if (la !== 1873) begin errors++; $display("FAIL busy_en_latency got=%0d exp=1873", la); end
    repeat (5) @(negedge clk);
    checks++;
    if ({rdy_a, done_a, key_ok_a} !== 3'b111) begin
      errors++; $display("FAIL done_hold got=%b exp=111", {rdy_a, done_a, key_ok_a});
    end
    checks++;
    if (q_a.size() != 0) begin errors++; $display("FAIL busy_en_writes got=%0d exp=0", q_a.size()); end
  endtask

  task automatic test_back_to_back();
    int la, lb, lc;
    for (int r = 0; r < 2; r++) begin
      key3 = 24'($urandom);
      key5 = {8'($urandom), $urandom};
      rc4_model(256'(key3), 3, 9);
      for (int n = 0; n < 9; n++) q_a.push_back({8'(n), m_ks[n] ^ ct_mem_ab[n]});
      rc4_model(256'(key5), 5, 1);
      q_c.push_back({8'h00, m_ks[0]});
      clear_pt();
      run(1'b1, 1'b0, 1'b1, 1'b0, la, lb, lc);
      checks++;
      if ({la, lc} !== {32'd1873, 32'd1801}) begin
        errors++; $display("FAIL b2b_latency key3=%h got=%0d/%0d exp=1873/1801", key3, la, lc);
      end
      checks++;
      if ({key_ok_a, key_ok_c} !== 2'b11) begin
        errors++; $display("FAIL b2b_key_ok got=%b exp=11", {key_ok_a, key_ok_c});
      end
      checks++;
      if (q_a.size() + q_c.size() != 0) begin
        errors++; $display("FAIL b2b_writes got=%0d exp=0", q_a.size() + q_c.size());
      end
    end
  endtask

  task automatic test_reset_mid_ksa();
    int la, lb, lc;
    key3 = 24'h4B6579;
    @(negedge clk);
    en_a = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    en_a = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (cyc - t0 == 856) break;
    end
    checks++;
    if (s_addr_a !== 8'd100) begin errors++; $display("FAIL ksa_i100 got=%0d exp=100", s_addr_a); end
    rst = 1'b1;
    en_a = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy_a, done_a, key_ok_a, s_wren_a, pt_wren_a} !== 5'b10000) begin
      errors++; $display("FAIL midrun_reset_flags got=%b exp=10000", {rdy_a, done_a, key_ok_a, s_wren_a, pt_wren_a});
    end
    checks++;
    if ({s_addr_a, s_din_a, ct_addr_a, pt_addr_a} !== 24'h0) begin
      errors++; $display("FAIL midrun_reset_addr got=%h exp=0", {s_addr_a, s_din_a, ct_addr_a, pt_addr_a});
    end
    rst = 1'b0;
    en_a = 1'b0;
    clear_pt();
    push_plaintext_a();
    run(1'b1, 1'b0, 1'b0, 1'b0, la, lb, lc);
    checks++;
    if ({la, 31'd0, key_ok_a} !== {32'd1873, 32'd1}) begin
      errors++; $display("FAIL rerun_after_reset got=%0d/%b exp=1873/1", la, key_ok_a);
    end
    checks++;
    if (q_a.size() != 0) begin errors++; $display("FAIL rerun_writes got=%0d exp=0", q_a.size()); end
  endtask

  initial begin
    rst = 1'b1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    pt_clear = 1'b0;
    key3 = 24'h4B6579;
    key5 = 40'h0102030405;
    test_reset();
    test_vectors();
    test_busy_en();
    test_back_to_back();
    test_reset_mid_ksa();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
